// File: rtl/vga_pkg.sv
// vga_pkg: shared timing defaults, colour constants and mover state encoding.
package vga_pkg;
   localparam int H_ACTIVE_DEF = 640;
   localparam int V_ACTIVE_DEF = 480;
   localparam logic [2:0] COLOR_BLACK = 3'b000;
   localparam logic [2:0] COLOR_BG    = 3'b001;
   localparam logic [2:0] COLOR_RESET = 3'b100;
   typedef enum logic {S_HOLD = 1'b0, S_RUN = 1'b1} state_t;
   // Colour cycles 1..7 and skips black so the sprite never vanishes.
   function automatic logic [2:0] next_colour(input logic [2:0] c);
      return (c == 3'd7) ? 3'd1 : c + 3'd1;
   endfunction
endpackage

// File: rtl/vga_box_mover.sv
// vga_box_mover: sprite position/direction/colour state, stepped once per frame with edge bounce.
module vga_box_mover
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int BOX_SIZE = 32,
   parameter int STEP     = 2
) (
   input  logic       clk_25,
   input  logic       reset_n,
   input  logic       update,
   input  logic       enable,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic [2:0] colour
);
   localparam logic [10:0] X_MAX = 11'(H_ACTIVE - BOX_SIZE);
   localparam logic [10:0] Y_MAX = 11'(V_ACTIVE - BOX_SIZE);
   localparam logic [10:0] STP   = 11'(STEP);
   state_t state;
   logic dx, dy, bx, by;
   logic [10:0] xs, ys;
   logic [9:0] x_nxt, y_nxt;
   always_comb begin
      xs    = {1'b0, x} + STP;
      ys    = {1'b0, y} + STP;
      bx    = dx ? (xs >= X_MAX) : (x <= STP[9:0]);
      by    = dy ? (ys >= Y_MAX) : (y <= STP[9:0]);
      x_nxt = dx ? (bx ? X_MAX[9:0] : xs[9:0]) : (bx ? 10'd0 : x - STP[9:0]);
      y_nxt = dy ? (by ? Y_MAX[9:0] : ys[9:0]) : (by ? 10'd0 : y - STP[9:0]);
   end
   always_ff @(posedge clk_25 or negedge reset_n) begin
      if (!reset_n) begin
         state  <= S_HOLD;
         x      <= X_MAX[10:1];
         y      <= Y_MAX[10:1];
         dx     <= 1'b1;
         dy     <= 1'b1;
         colour <= COLOR_RESET;
      end else if (update) begin
         state <= enable ? S_RUN : S_HOLD;
         // The old state decides motion, so the entering update does not move.
         if (state == S_RUN) begin
            x  <= x_nxt;
            y  <= y_nxt;
            dx <= bx ? ~dx : dx;
            dy <= by ? ~dy : dy;
            if (bx || by) colour <= next_colour(colour);
         end
      end
   end
endmodule

// File: rtl/vga_sprite_engine.sv
// vga_sprite_engine: draws a bouncing square sprite over a background,
// registering rgb and syncs one cycle behind the incoming counters.
module vga_sprite_engine
   import vga_pkg::*;
#(
   parameter int         H_ACTIVE = H_ACTIVE_DEF,
   parameter int         V_ACTIVE = V_ACTIVE_DEF,
   parameter int         BOX_SIZE = 32,
   parameter int         STEP     = 2,
   parameter logic [2:0] BG_COLOR = COLOR_BG
) (
   input  logic       clk_25,
   input  logic       reset_n,
   input  logic       enable,
   input  logic [9:0] h_count,
   input  logic [9:0] v_count,
   input  logic       bright,
   input  logic       h_sync_in,
   input  logic       v_sync_in,
   output logic [2:0] rgb,
   output logic       hs,
   output logic       vs,
   output logic       frame_tick
);
   logic [9:0] x, y;
   logic [2:0] colour;
   logic update, in_box;
   // First pixel of the first blanking line: once per frame, outside the visible area.
   assign update = (h_count == 10'd0) && (v_count == 10'(V_ACTIVE));
   assign in_box = ({1'b0, h_count} >= {1'b0, x}) && ({1'b0, h_count} < {1'b0, x} + 11'(BOX_SIZE)) &&
                   ({1'b0, v_count} >= {1'b0, y}) && ({1'b0, v_count} < {1'b0, y} + 11'(BOX_SIZE));
   vga_box_mover #(
      .H_ACTIVE(H_ACTIVE),
      .V_ACTIVE(V_ACTIVE),
      .BOX_SIZE(BOX_SIZE),
      .STEP    (STEP)
   ) u_mover (
      .clk_25 (clk_25),
      .reset_n(reset_n),
      .update (update),
      .enable (enable),
      .x      (x),
      .y      (y),
      .colour (colour)
   );
   always_ff @(posedge clk_25 or negedge reset_n) begin
      if (!reset_n) begin
         rgb        <= COLOR_BLACK;
         hs         <= 1'b1;
         vs         <= 1'b1;
         frame_tick <= 1'b0;
      end else begin
         rgb        <= !bright ? COLOR_BLACK : in_box ? colour : BG_COLOR;
         hs         <= h_sync_in;
         vs         <= v_sync_in;
         frame_tick <= update;
      end
   end
endmodule

// File: tb/tb_vga_sprite_engine.sv
// tb_vga_sprite_engine: randomized pixel/frame stimulus checked against a
// geometric model of the bouncing sprite.
module tb_vga_sprite_engine;
   localparam int HA = 640, VA = 480, BS = 32, ST = 2;
   logic clk_25 = 1'b0, reset_n = 1'b0, enable = 1'b0, bright = 1'b0;
   logic h_sync_in = 1'b1, v_sync_in = 1'b1;
   logic [9:0] h_count = '0, v_count = '0;
   logic [2:0] rgb;
   logic hs, vs, frame_tick;
   int checks = 0, failures = 0;
   int mx, my, mdx, mdy, mcol;
   bit mrun;

   always #20 clk_25 = ~clk_25;

   vga_sprite_engine dut (
      .clk_25    (clk_25),
      .reset_n   (reset_n),
      .enable    (enable),
      .h_count   (h_count),
      .v_count   (v_count),
      .bright    (bright),
      .h_sync_in (h_sync_in),
      .v_sync_in (v_sync_in),
      .rgb       (rgb),
      .hs        (hs),
      .vs        (vs),
      .frame_tick(frame_tick)
   );

   function automatic logic [2:0] exp_rgb(int h, int v, bit b);
      if (!b) return 3'b000;
      if (h >= mx && h < mx + BS && v >= my && v < my + BS) return 3'(mcol);
      return 3'b001;
   endfunction

   task automatic model_reset();
      mx = (HA - BS) / 2; my = (VA - BS) / 2; mdx = 1; mdy = 1; mcol = 4; mrun = 0;
   endtask

   task automatic model_update(bit en);
      int nx, ny;
      bit hit;
      hit = 0;
      if (mrun) begin
         nx = mx + mdx * ST;
         ny = my + mdy * ST;
         if (nx >= HA - BS) begin mx = HA - BS; mdx = -1; hit = 1; end
         else if (nx <= 0) begin mx = 0; mdx = 1; hit = 1; end
         else mx = nx;
         if (ny >= VA - BS) begin my = VA - BS; mdy = -1; hit = 1; end
         else if (ny <= 0) begin my = 0; mdy = 1; hit = 1; end
         else my = ny;
         if (hit) mcol = mcol % 7 + 1;
      end
      mrun = en;
   endtask

   task automatic probe(int h, int v, bit b, string nm);
      bit hi, vi;
      hi = 1'($urandom_range(0, 1));
      vi = 1'($urandom_range(0, 1));
      @(negedge clk_25);
      h_count = 10'(h); v_count = 10'(v); bright = b; h_sync_in = hi; v_sync_in = vi;
      @(posedge clk_25); #1;
      checks++;
      if (rgb !== exp_rgb(h, v, b)) begin
         failures++;
         $display("FAIL %s rgb at (%0d,%0d,b=%0d): got %b expected %b", nm, h, v, b, rgb, exp_rgb(h, v, b));
      end
      checks++;
      if ({hs, vs, frame_tick} !== {hi, vi, 1'b0}) begin
         failures++;
         $display("FAIL %s hs/vs/tick: got %b%b%b expected %b%b0", nm, hs, vs, frame_tick, hi, vi);
      end
   endtask

   task automatic frame(bit en);
      @(negedge clk_25);
      h_count = 10'd0; v_count = 10'(VA); bright = 1'b0; enable = en;
      @(posedge clk_25); #1;
      checks++;
      if ({frame_tick, rgb} !== 4'b1000) begin
         failures++;
         $display("FAIL frame_tick: got tick=%b rgb=%b expected tick=1 rgb=000", frame_tick, rgb);
      end
      model_update(en);
      probe(mx, my, 1, "box_tl");
      probe(mx + BS - 1, my + BS - 1, 1, "box_br");
      if (mx + BS < HA) probe(mx + BS, my, 1, "right_of_box");
      if (mx > 0) probe(mx - 1, my + 5, 1, "left_of_box");
      if (my > 0) probe(mx + 3, my - 1, 1, "above_box");
      if (my + BS < VA) probe(mx, my + BS, 1, "below_box");
   endtask

   task automatic test_reset();
      @(negedge clk_25);
      h_count = 10'd310; v_count = 10'd230; bright = 1'b1; h_sync_in = 1'b0; v_sync_in = 1'b0;
      @(posedge clk_25); #1;
      checks++;
      if ({rgb, hs, vs} !== {exp_rgb(310, 230, 1), 2'b00}) begin
         failures++;
         $display("FAIL pre_reset: got rgb=%b hs=%b vs=%b expected %b 0 0", rgb, hs, vs, exp_rgb(310, 230, 1));
      end
      #5 reset_n = 1'b0;
      #1;
      checks++;
      if ({rgb, hs, vs, frame_tick} !== 6'b000110) begin
         failures++;
         $display("FAIL async_reset: got rgb=%b hs=%b vs=%b tick=%b expected 000 1 1 0", rgb, hs, vs, frame_tick);
      end
      @(posedge clk_25); #1;
      checks++;
      if ({rgb, hs, vs, frame_tick} !== 6'b000110) begin
         failures++;
         $display("FAIL reset_held: got rgb=%b hs=%b vs=%b tick=%b expected 000 1 1 0", rgb, hs, vs, frame_tick);
      end
      @(negedge clk_25);
      reset_n = 1'b1;
      model_reset();
      probe(304, 224, 1, "reset_pos_tl");
      probe(303, 224, 1, "reset_pos_left");
      probe(335, 255, 1, "reset_pos_br");
      probe(336, 255, 1, "reset_pos_right");
      probe(320, 223, 1, "reset_pos_above");
   endtask

   task automatic test_pixel_map();
      enable = 1'b0;
      probe(310, 230, 1, "map_box");
      probe(0, 0, 1, "map_bg");
      probe(310, 230, 0, "map_blank");
      probe(639, 479, 1, "map_corner_bg");
   endtask

   task automatic test_motion();
      for (int i = 0; i < 3; i++) frame(1'b1);
   endtask

   task automatic test_freeze();
      for (int i = 0; i < 6; i++) frame(1'b0);
   endtask

   task automatic test_bounce();
      for (int i = 0; i < 450; i++) frame($urandom_range(0, 7) != 0);
   endtask

   task automatic test_back_to_back();
      int h, v;
      for (int i = 0; i < 200; i++) begin
         h = $urandom_range(0, 799);
         v = $urandom_range(0, 524);
         if (h == 0 && v == VA) h = 1;
         probe(h, v, 1'($urandom_range(0, 1)), "stream");
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL timeout: simulation exceeded its time budget");
      $fatal(1);
   end

   initial begin
      model_reset();
      repeat (3) @(negedge clk_25);
      reset_n = 1'b1;
      test_reset();
      test_pixel_map();
      test_motion();
      test_freeze();
      test_bounce();
      test_back_to_back();
      test_motion();
      test_reset();
      test_pixel_map();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
